regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 119 +++++++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: combinational reads, clocked writes (highest port wins),
// optional same-cycle forwarding, and a valid/ready register dump triggered when the core halts.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 0,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [NRD*AW-1:0]    rs_num,
  output logic [NRD*XLEN-1:0]  rs_data,
  input  logic [NWR*AW-1:0]    rd_num,
  input  logic [NWR*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       rd_we,
  input  logic                 halted,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [AW-1:0]        dump_idx,
  output logic [XLEN-1:0]      dump_data,
  output logic                 dump_done,
  output logic [1:0]           dbg_state
);

  // Dump handshake: a beat moves on a rising clk edge where dump_valid and dump_ready
  // are both 1; dump_idx/dump_data are held while dump_valid=1 and dump_ready=0.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DUMP = 2'd1, S_DONE = 2'd2} state_t;

  logic [XLEN-1:0] reg_q [NREGS];
  logic [XLEN-1:0] reg_d [NREGS];

  state_t          state_q, state_d;
  logic [AW-1:0]   dump_idx_q, dump_idx_d;
  logic            halted_q, halted_d;
  logic            seen_low_q, seen_low_d;

  // Ascending port order lets the highest-numbered port overwrite the others.
  always_comb begin
    reg_d = reg_q;
    for (int j = 0; j < NWR; j++) begin
      if (rd_we[j]) reg_d[rd_num[j*AW +: AW]] = rd_data[j*XLEN +: XLEN];
    end
    reg_d[0] = '0;
  end

  always_comb begin
    rs_data = '0;
    for (int k = 0; k < NRD; k++) begin
      rs_data[k*XLEN +: XLEN] = reg_q[rs_num[k*AW +: AW]];
      if (BYPASS != 0 && rs_num[k*AW +: AW] != '0) begin
        for (int j = 0; j < NWR; j++) begin
          if (rd_we[j] && rd_num[j*AW +: AW] == rs_num[k*AW +: AW])
            rs_data[k*XLEN +: XLEN] = rd_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // seen_low_q blocks a start until halted has been observed low since reset,
  // so a halted line held high through reset does not look like a fresh rise.
  always_comb begin
    state_d    = state_q;
    dump_idx_d = dump_idx_q;
    halted_d   = halted;
    seen_low_d = seen_low_q | ~halted;
    case (state_q)
      S_IDLE: begin
        if (halted && !halted_q && seen_low_q) begin
          state_d    = S_DUMP;
          dump_idx_d = '0;
        end
      end
      S_DUMP: begin
        if (!halted) begin
          state_d    = S_IDLE;
          dump_idx_d = '0;
        end else if (dump_ready) begin
          if (dump_idx_q == AW'(NREGS - 1)) state_d = S_DONE;
          else                              dump_idx_d = dump_idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!halted) begin
          state_d    = S_IDLE;
          dump_idx_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        dump_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREGS; i++) reg_q[i] <= '0;
      state_q    <= S_IDLE;
      dump_idx_q <= '0;
      halted_q   <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      reg_q      <= reg_d;
      state_q    <= state_d;
      dump_idx_q <= dump_idx_d;
      halted_q   <= halted_d;
      seen_low_q <= seen_low_d;
    end
  end

  assign dump_valid = (state_q == S_DUMP);
  assign dump_done  = (state_q == S_DONE);
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_valid ? reg_q[dump_idx_q] : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share stimulus and
// are checked against an array model of the register contents.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2, NWR = 2;

  logic                clk = 1'b0;
  logic                rst_b = 1'b0;
  logic [NRD*AW-1:0]   rs_num = '0;
  logic [NRD*XLEN-1:0] rs_data, rs_data_nb;
  logic [NWR*AW-1:0]   rd_num = '0;
  logic [NWR*XLEN-1:0] rd_data = '0;
  logic [NWR-1:0]      rd_we = '0;
  logic                halted = 1'b0;
  logic                dump_ready = 1'b0;
  logic                dump_valid, dump_done, dump_valid_nb, dump_done_nb;
  logic [AW-1:0]       dump_idx, dump_idx_nb;
  logic [XLEN-1:0]     dump_data, dump_data_nb;
  logic [1:0]          dbg_state, dbg_state_nb;

  int total = 0;
  int bad = 0;
  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] exp_q [$];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst_b(rst_b), .rs_num(rs_num), .rs_data(rs_data),
    .rd_num(rd_num), .rd_data(rd_data), .rd_we(rd_we), .halted(halted),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_done(dump_done), .dbg_state(dbg_state));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_b(rst_b), .rs_num(rs_num), .rs_data(rs_data_nb),
    .rd_num(rd_num), .rd_data(rd_data), .rd_we(rd_we), .halted(halted),
    .dump_valid(dump_valid_nb), .dump_ready(dump_ready), .dump_idx(dump_idx_nb),
    .dump_data(dump_data_nb), .dump_done(dump_done_nb), .dbg_state(dbg_state_nb));

  always #5 clk = ~clk;

  // One clock: the model commits the writes presented at the rising edge.
  task automatic step();
    @(posedge clk);
    if (rst_b) begin
      for (int j = 0; j < NWR; j++)
        if (rd_we[j] && rd_num[j*AW +: AW] != 0) model[rd_num[j*AW +: AW]] = rd_data[j*XLEN +: XLEN];
    end
    @(negedge clk);
    #1;
  endtask

  task automatic set_wr(int j, bit we, int idx, logic [XLEN-1:0] data);
    rd_we[j] = we;
    rd_num[j*AW +: AW] = AW'(idx);
    rd_data[j*XLEN +: XLEN] = data;
  endtask

  task automatic set_rd(int k, int idx);
    rs_num[k*AW +: AW] = AW'(idx);
  endtask

  // Forwarded value: the highest enabled port writing a nonzero index overrides storage.
  function automatic logic [XLEN-1:0] exp_read(int idx, bit byp);
    logic [XLEN-1:0] v;
    v = model[idx];
    if (byp && idx != 0)
      for (int j = 0; j < NWR; j++)
        if (rd_we[j] && int'(rd_num[j*AW +: AW]) == idx) v = rd_data[j*XLEN +: XLEN];
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    clear_model();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", dump_valid); end
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", dump_done); end
    total++; if (dump_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", dump_idx); end
    total++; if (dump_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", dump_data); end
    set_rd(0, 5); set_rd(1, 31);
    #1;
    total++; if (rs_data !== '0) begin bad++; $display("FAIL reset_regs got=%h want=0", rs_data); end
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_wr(0, 1'b1, 5, 32'hDEADBEEF);
    step();
    rd_we = '0;
    set_rd(0, 5); set_rd(1, 5);
    #1;
    for (int k = 0; k < NRD; k++) begin
      total++; if (rs_data[k*XLEN +: XLEN] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_x5 port=%0d got=%h want=deadbeef", k, rs_data[k*XLEN +: XLEN]); end
      total++; if (rs_data_nb[k*XLEN +: XLEN] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_x5_nb port=%0d got=%h want=deadbeef", k, rs_data_nb[k*XLEN +: XLEN]); end
    end
    set_wr(0, 1'b1, 0, 32'hFFFFFFFF);
    set_rd(0, 0); set_rd(1, 0);
    #1;
    total++; if (rs_data[XLEN-1:0] !== '0) begin bad++; $display("FAIL x0_bypass got=%h want=0", rs_data[XLEN-1:0]); end
    step();
    rd_we = '0;
    #1;
    total++; if (rs_data !== '0) begin bad++; $display("FAIL x0_after got=%h want=0", rs_data); end
    total++; if (rs_data_nb !== '0) begin bad++; $display("FAIL x0_after_nb got=%h want=0", rs_data_nb); end
  endtask

  task automatic test_collision();
    set_wr(0, 1'b1, 7, 32'h11);
    set_wr(1, 1'b1, 7, 32'h22);
    set_rd(0, 7);
    #1;
    total++; if (rs_data[XLEN-1:0] !== 32'h22) begin bad++; $display("FAIL collide_fwd got=%h want=22", rs_data[XLEN-1:0]); end
    step();
    rd_we = '0;
    #1;
    total++; if (rs_data[XLEN-1:0] !== 32'h22) begin bad++; $display("FAIL collide_x7 got=%h want=22", rs_data[XLEN-1:0]); end
    total++; if (rs_data_nb[XLEN-1:0] !== 32'h22) begin bad++; $display("FAIL collide_x7_nb got=%h want=22", rs_data_nb[XLEN-1:0]); end
  endtask

  task automatic test_bypass();
    set_wr(0, 1'b1, 3, 32'hAA);
    step();
    set_wr(0, 1'b1, 3, 32'h55);
    set_rd(0, 3); set_rd(1, 3);
    #1;
    total++; if (rs_data[XLEN-1:0] !== 32'h55) begin bad++; $display("FAIL bypass_on got=%h want=55", rs_data[XLEN-1:0]); end
    total++; if (rs_data[XLEN +: XLEN] !== 32'h55) begin bad++; $display("FAIL bypass_on_p1 got=%h want=55", rs_data[XLEN +: XLEN]); end
    total++; if (rs_data_nb[XLEN-1:0] !== 32'hAA) begin bad++; $display("FAIL bypass_off got=%h want=aa", rs_data_nb[XLEN-1:0]); end
    step();
    rd_we = '0;
    #1;
    total++; if (rs_data_nb[XLEN-1:0] !== 32'h55) begin bad++; $display("FAIL bypass_after got=%h want=55", rs_data_nb[XLEN-1:0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < NWR; j++) set_wr(j, 1'($urandom_range(0, 1)), $urandom_range(0, NREGS-1), $urandom);
      if ($urandom_range(0, 3) == 0) rd_num[AW +: AW] = rd_num[0 +: AW];
      for (int k = 0; k < NRD; k++) begin
        if ($urandom_range(0, 1) == 1) rs_num[k*AW +: AW] = rd_num[$urandom_range(0, NWR-1)*AW +: AW];
        else set_rd(k, $urandom_range(0, NREGS-1));
      end
      #1;
      for (int k = 0; k < NRD; k++) begin
        total++;
        if (rs_data[k*XLEN +: XLEN] !== exp_read(int'(rs_num[k*AW +: AW]), 1'b1)) begin
          bad++; $display("FAIL rand_fwd n=%0d port=%0d idx=%0d got=%h want=%h", n, k, rs_num[k*AW +: AW], rs_data[k*XLEN +: XLEN], exp_read(int'(rs_num[k*AW +: AW]), 1'b1));
        end
        total++;
        if (rs_data_nb[k*XLEN +: XLEN] !== exp_read(int'(rs_num[k*AW +: AW]), 1'b0)) begin
          bad++; $display("FAIL rand_nofwd n=%0d port=%0d idx=%0d got=%h want=%h", n, k, rs_num[k*AW +: AW], rs_data_nb[k*XLEN +: XLEN], exp_read(int'(rs_num[k*AW +: AW]), 1'b0));
        end
      end
      step();
    end
    rd_we = '0;
  endtask

  task automatic test_dump_full();
    logic [XLEN-1:0] e;
    for (int i = 1; i < NREGS; i += 2) begin
      set_wr(0, 1'b1, i, XLEN'(i));
      set_wr(1, (i + 1 < NREGS), (i + 1) % NREGS, XLEN'(i + 1));
      step();
    end
    rd_we = '0;
    halted = 1'b0;
    step();
    for (int i = 0; i < NREGS; i++) exp_q.push_back(XLEN'(i));
    halted = 1'b1; dump_ready = 1'b1;
    step();
    for (int i = 0; i < NREGS; i++) begin
      e = exp_q.pop_front();
      total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL full_valid beat=%0d got=%0b want=1", i, dump_valid); end
      total++; if (dump_idx !== AW'(i)) begin bad++; $display("FAIL full_idx beat=%0d got=%0d want=%0d", i, dump_idx, i); end
      total++; if (dump_data !== e) begin bad++; $display("FAIL full_data beat=%0d got=%h want=%h", i, dump_data, e); end
      step();
    end
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL full_end_valid got=%0b want=0", dump_valid); end
    total++; if (dump_done !== 1'b1) begin bad++; $display("FAIL full_end_done got=%0b want=1", dump_done); end
    step();
    total++; if (dump_done !== 1'b1) begin bad++; $display("FAIL full_done_hold got=%0b want=1", dump_done); end
    halted = 1'b0;
    step();
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL full_release got=%0b want=0", dump_done); end
  endtask

  task automatic test_dump_stall();
    int exp_idx;
    int cyc;
    exp_idx = 0; cyc = 0;
    halted = 1'b1; dump_ready = 1'b0;
    step();
    while (exp_idx < NREGS && cyc < 300) begin
      dump_ready = cyc[0];
      set_wr(0, ($urandom_range(0, 3) == 0), $urandom_range(1, NREGS-1), $urandom);
      #1;
      total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%0b want=1", cyc, dump_valid); end
      total++; if (dump_idx !== AW'(exp_idx)) begin bad++; $display("FAIL stall_idx cyc=%0d got=%0d want=%0d", cyc, dump_idx, exp_idx); end
      total++; if (dump_data !== model[exp_idx]) begin bad++; $display("FAIL stall_data cyc=%0d got=%h want=%h", cyc, dump_data, model[exp_idx]); end
      if (dump_ready) exp_idx++;
      step();
      cyc++;
    end
    rd_we = '0;
    total++; if (exp_idx != NREGS) begin bad++; $display("FAIL stall_timeout beats=%0d want=%0d", exp_idx, NREGS); end
    total++; if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin bad++; $display("FAIL stall_end done=%0b valid=%0b want done=1 valid=0", dump_done, dump_valid); end
    halted = 1'b0; dump_ready = 1'b0;
    step();
  endtask

  task automatic test_abort();
    halted = 1'b1; dump_ready = 1'b1;
    repeat (4) step();
    total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL abort_pre got=%0b want=1", dump_valid); end
    halted = 1'b0;
    step();
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", dump_valid); end
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b want=0", dump_done); end
    step();
  endtask

  task automatic test_reset_mid();
    halted = 1'b1; dump_ready = 1'b1;
    step();
    repeat (10) step();
    total++; if (dump_idx !== AW'(10)) begin bad++; $display("FAIL mid_idx got=%0d want=10", dump_idx); end
    rst_b = 1'b0;
    clear_model();
    set_rd(0, 5); set_rd(1, 7);
    #1;
    total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", dump_valid); end
    total++; if (dump_idx !== '0) begin bad++; $display("FAIL mid_idx0 got=%0d want=0", dump_idx); end
    total++; if (dump_data !== '0) begin bad++; $display("FAIL mid_data got=%h want=0", dump_data); end
    total++; if (dump_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", dump_done); end
    total++; if (rs_data !== '0) begin bad++; $display("FAIL mid_regs got=%h want=0", rs_data); end
    repeat (2) step();
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL mid_norestart cyc=%0d got=%0b want=0", i, dump_valid); end
    end
    halted = 1'b0;
    step();
    halted = 1'b1;
    step();
    total++; if (dump_valid !== 1'b1) begin bad++; $display("FAIL mid_restart_valid got=%0b want=1", dump_valid); end
    total++; if (dump_idx !== '0) begin bad++; $display("FAIL mid_restart_idx got=%0d want=0", dump_idx); end
    halted = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_random();
    test_dump_full();
    test_dump_stall();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
